// File: rtl/data_cache_port_arbiter_if.sv
// Port0 handshake bundle shared by the load, store and refill requesters and the arbiter.
//   refill_request_i / refill_done_i / refill_granted_o : memory unit (refill/writeback)
//   store_request_i / store_done_i / store_idle_i / store_granted_o : store cache controller
//   load_request_i / load_done_i / load_granted_o : load cache controller
//   port0_owner_o (00 none, 01 load, 10 store, 11 refill), port0_busy_o : port status
interface data_cache_port_arbiter_if;
    logic       refill_request_i;
    logic       refill_done_i;
    logic       refill_granted_o;
    logic       store_request_i;
    logic       store_done_i;
    logic       store_idle_i;
    logic       store_granted_o;
    logic       load_request_i;
    logic       load_done_i;
    logic       load_granted_o;
    logic [1:0] port0_owner_o;
    logic       port0_busy_o;

    // Requester side: drives requests/releases, observes grants.
    modport master (
        output refill_request_i, refill_done_i,
        output store_request_i, store_done_i, store_idle_i,
        output load_request_i, load_done_i,
        input  refill_granted_o, store_granted_o, load_granted_o,
        input  port0_owner_o, port0_busy_o
    );

    // Arbiter side.
    modport slave (
        input  refill_request_i, refill_done_i,
        input  store_request_i, store_done_i, store_idle_i,
        input  load_request_i, load_done_i,
        output refill_granted_o, store_granted_o, load_granted_o,
        output port0_owner_o, port0_busy_o
    );
endinterface

// File: rtl/data_cache_port_arbiter.sv
// Data cache port0 arbiter between load controller, store controller and refill unit.
// Refill has priority unless load/store have been starved STARVE_LIMIT times; load and
// store alternate round-robin. Grants are combinational in IDLE and held by the owner
// until its release (done, or store idle).
// Ports: clk_i, rst_n_i (async active-low), port0 (data_cache_port_arbiter_if.slave).
module data_cache_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    data_cache_port_arbiter_if.slave  port0
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    // Encoding doubles as the port0_owner_o code.
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        OWN_LOAD   = 2'b01,
        OWN_STORE  = 2'b10,
        OWN_REFILL = 2'b11
    } state_t;

    state_t             state_q, state_d;
    state_t             winner;
    state_t             owner;
    logic               last_store_q, last_store_d;   // 1: store was served last
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               ls_pending;
    logic               starved;

    // State register, round-robin pointer and starvation counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            last_store_q <= 1'b1;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            last_store_q <= last_store_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state, arbitration and counter update.
    always_comb begin
        state_d      = state_q;
        last_store_d = last_store_q;
        starve_cnt_d = starve_cnt_q;
        winner       = IDLE;
        ls_pending   = port0.load_request_i | port0.store_request_i;
        starved      = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

        case (state_q)
            IDLE: begin
                if (port0.refill_request_i && !(starved && ls_pending)) begin
                    winner = OWN_REFILL;
                end else if (port0.load_request_i && port0.store_request_i) begin
                    winner = last_store_q ? OWN_LOAD : OWN_STORE;
                end else if (port0.load_request_i) begin
                    winner = OWN_LOAD;
                end else if (port0.store_request_i) begin
                    winner = OWN_STORE;
                end
                state_d = winner;

                if (winner == OWN_REFILL && ls_pending && !starved) begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
                if (winner == OWN_LOAD || winner == OWN_STORE) begin
                    starve_cnt_d = '0;
                    last_store_d = (winner == OWN_STORE);
                end
            end
            OWN_LOAD: begin
                if (port0.load_done_i) state_d = IDLE;
            end
            OWN_STORE: begin
                // Invalidate-miss exits through store_idle_i without a done.
                if (port0.store_done_i || port0.store_idle_i) state_d = IDLE;
            end
            OWN_REFILL: begin
                if (port0.refill_done_i) state_d = IDLE;
            end
        endcase
    end

    // Owner is the live winner in IDLE; reset also masks grants from live requests.
    always_comb begin
        owner = (state_q == IDLE) ? winner : state_q;
        if (!rst_n_i) owner = IDLE;
    end

    assign port0.load_granted_o   = (owner == OWN_LOAD);
    assign port0.store_granted_o  = (owner == OWN_STORE);
    assign port0.refill_granted_o = (owner == OWN_REFILL);
    assign port0.port0_owner_o    = 2'(owner);
    assign port0.port0_busy_o     = (owner != IDLE);

endmodule

// File: tb/tb_data_cache_port_arbiter.sv
// Randomized + directed bench for data_cache_port_arbiter against a behavioural model.
module tb_data_cache_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic clk_i;
    logic rst_n_i;
    int   n_checks;
    int   n_fail;

    // Reference model: owner (0 none, 1 load, 2 store, 3 refill), starvation count, last served.
    int   m_owner;
    int   m_starve;
    int   m_last_store;

    data_cache_port_arbiter_if bus ();

    data_cache_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .port0   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner      = 0;
        m_starve     = 0;
        m_last_store = 1;
    endtask

    // Who should own port0 in the current cycle given the model and the driven requests.
    function automatic int model_owner();
        bit ls;
        if (m_owner != 0) return m_owner;
        ls = bus.load_request_i || bus.store_request_i;
        if (bus.refill_request_i && !(m_starve == LIMIT && ls)) return 3;
        if (bus.load_request_i && bus.store_request_i) return (m_last_store == 1) ? 1 : 2;
        if (bus.load_request_i) return 1;
        if (bus.store_request_i) return 2;
        return 0;
    endfunction

    task automatic model_advance(input int exp_owner);
        bit ls;
        ls = bus.load_request_i || bus.store_request_i;
        if (m_owner == 0) begin
            if (exp_owner == 3 && ls && m_starve < LIMIT) m_starve++;
            if (exp_owner == 1 || exp_owner == 2) begin
                m_starve     = 0;
                m_last_store = (exp_owner == 2) ? 1 : 0;
            end
            m_owner = exp_owner;
        end else if ((m_owner == 1 && bus.load_done_i) ||
                     (m_owner == 2 && (bus.store_done_i || bus.store_idle_i)) ||
                     (m_owner == 3 && bus.refill_done_i)) begin
            m_owner = 0;
        end
    endtask

    task automatic drive(input bit rf, input bit rfd, input bit st, input bit sd,
                         input bit si, input bit ld, input bit ldd);
        bus.refill_request_i = rf;
        bus.refill_done_i    = rfd;
        bus.store_request_i  = st;
        bus.store_done_i     = sd;
        bus.store_idle_i     = si;
        bus.load_request_i   = ld;
        bus.load_done_i      = ldd;
    endtask

    // One clock: drive at negedge, compare mid-cycle, advance model at the rising edge.
    task automatic step(input string tag, input bit rf, input bit rfd, input bit st,
                        input bit sd, input bit si, input bit ld, input bit ldd);
        int          exp;
        logic [2:0]  exp_g;
        @(negedge clk_i);
        drive(rf, rfd, st, sd, si, ld, ldd);
        #1;
        exp   = model_owner();
        exp_g = {exp == 3, exp == 2, exp == 1};
        check_eq({tag, "_grants"}, 32'({bus.refill_granted_o, bus.store_granted_o, bus.load_granted_o}),
                 32'(exp_g));
        check_eq({tag, "_owner"}, 32'(bus.port0_owner_o), 32'(exp));
        check_eq({tag, "_busy"}, 32'(bus.port0_busy_o), 32'(exp != 0));
        @(posedge clk_i);
        model_advance(exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;

        // Reset state, and live requests masked while reset is held.
        check_eq("rst_owner", 32'(bus.port0_owner_o), 32'd0);
        check_eq("rst_busy", 32'(bus.port0_busy_o), 32'd0);
        drive(1, 0, 1, 0, 0, 1, 0);
        #1;
        check_eq("rst_mask_grants",
                 32'({bus.refill_granted_o, bus.store_granted_o, bus.load_granted_o}), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Store alone: granted same cycle, held 3 cycles, released by done, IDLE after.
        step("st_grant", 0, 0, 1, 0, 0, 0, 0);
        check_eq("st_owner10", 32'(bus.port0_owner_o), 32'd2);
        for (int i = 0; i < 3; i++) step("st_hold", 0, 0, 1, 0, 0, 0, 0);
        step("st_done", 0, 0, 1, 1, 0, 0, 0);
        step("st_after", 0, 0, 0, 0, 0, 0, 0);

        // Load/store tie alternates: load first (store served last), then store.
        step("tie1", 0, 0, 1, 0, 0, 1, 0);
        check_eq("tie1_load", 32'(bus.load_granted_o), 32'd1);
        step("tie1_rel", 0, 0, 1, 0, 0, 1, 1);
        step("tie2", 0, 0, 1, 0, 0, 1, 0);
        check_eq("tie2_store", 32'(bus.store_granted_o), 32'd1);
        step("tie2_rel", 0, 0, 1, 1, 0, 1, 0);

        // Starvation: refill wins LIMIT times with store waiting, then store wins.
        for (int i = 0; i <= int'(LIMIT); i++) begin
            @(negedge clk_i);
            drive(1, 0, 1, 0, 0, 0, 0);
            #1;
            check_eq("starve_arb", 32'(bus.port0_owner_o), (i < int'(LIMIT)) ? 32'd3 : 32'd2);
            @(posedge clk_i);
            model_advance(model_owner());
            step("starve_rel", 1, 1, 1, 1, 0, 0, 0);
        end
        check_eq("starve_clear", 32'(dut.starve_cnt_q), 32'd0);
        check_eq("starve_model", 32'(m_starve), 32'd0);

        // Store invalidate-miss release via store_idle_i.
        step("inv_grant", 0, 0, 1, 0, 0, 0, 0);
        step("inv_idle", 0, 0, 0, 0, 1, 0, 0);
        step("inv_after", 0, 0, 0, 0, 0, 0, 0);

        // Load owner ignores refill request and foreign done pulses.
        step("ld_grant", 0, 0, 0, 0, 0, 1, 0);
        step("ld_noise", 1, 1, 0, 1, 1, 0, 0);
        check_eq("ld_kept", 32'(bus.load_granted_o), 32'd1);
        step("ld_noise2", 1, 0, 1, 1, 0, 0, 0);
        step("ld_done", 1, 0, 0, 0, 0, 0, 1);
        step("ld_after", 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-refill ownership drops the grant asynchronously.
        step("rf_grant", 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        drive(1, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("rst_rf_grant", 32'(bus.refill_granted_o), 32'd0);
        check_eq("rst_rf_owner", 32'(bus.port0_owner_o), 32'd0);
        model_reset();
        drive(0, 0, 1, 0, 0, 0, 0);
        #1;
        rst_n_i = 1'b1;
        #1;
        check_eq("post_rst_store", 32'(bus.store_granted_o), 32'd1);
        @(posedge clk_i);
        model_advance(model_owner());
        step("post_rst_rel", 0, 0, 1, 1, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_cache_port_arbiter.md
DATA_CACHE_PORT_ARBITER -- requirements
Module: data_cache_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive refill wins allowed while load/store wait before refill priority is suspended.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  asynchronous active-low reset.
REQ-004 refill_request_i  input  1  memory unit (refill/writeback) requests data cache port0.
REQ-005 refill_done_i  input  1  refill owner releases port0 this cycle.
REQ-006 refill_granted_o  output  1  port0 granted to refill.
REQ-007 store_request_i  input  1  store cache controller requests port0.
REQ-008 store_done_i  input  1  store controller finished its operation.
REQ-009 store_idle_i  input  1  store controller next state is idle (covers invalidate-miss exit without done).
REQ-010 store_granted_o  output  1  port0 granted to store controller.
REQ-011 load_request_i  input  1  load cache controller requests port0.
REQ-012 load_done_i  input  1  load controller finished its operation.
REQ-013 load_granted_o  output  1  port0 granted to load controller.
REQ-014 port0_owner_o  output  2  current owner: 00 none, 01 load, 10 store, 11 refill.
REQ-015 port0_busy_o  output  1  an owner currently holds port0.

Function
REQ-016 FSM states SHALL be IDLE, OWN_LOAD, OWN_STORE, OWN_REFILL; reset state IDLE.
REQ-017 In IDLE the grant SHALL be combinational: the winner's granted_o asserts in the same cycle as its request, and the FSM moves to OWN_<winner> on the next edge.
REQ-018 IDLE priority SHALL be refill > load/store, unless starve_cnt == STARVE_LIMIT, in which case load/store SHALL beat refill.
REQ-019 Between load and store the SHALL be round-robin via a 1-bit last_served register: the requester not served last wins; ties with last_served = load grant store; last_served updates on each load/store grant.
REQ-020 At most one granted_o SHALL be high in any cycle.
REQ-021 In OWN_x, x_granted_o SHALL stay high every cycle, including the release cycle; all other requests SHALL be ignored.
REQ-022 Release: OWN_LOAD on load_done_i; OWN_STORE on store_done_i or store_idle_i; OWN_REFILL on refill_done_i; next state SHALL be IDLE (one-cycle arbitration bubble is not required -- release cycle goes to IDLE, new grant possible in the following cycle).
REQ-023 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment when refill wins in IDLE while load or store request is pending, saturate at STARVE_LIMIT, and clear when load or store is granted.
REQ-024 port0_owner_o and port0_busy_o SHALL reflect the registered state in OWN_x and the combinational winner in IDLE (busy = 1 whenever any grant is high).
REQ-025 Requests deasserting in IDLE before grant SHALL leave no side effect; no request SHALL leave outputs 00/0.
REQ-026 done_i from a non-owner SHALL be ignored.

Reset
REQ-027 On rst_n_i low, immediately: state IDLE, all granted_o 0 (unless combinational IDLE grant from live requests -- reset SHALL force grants 0 while asserted), port0_owner_o 00, port0_busy_o 0, starve_cnt 0, last_served = store (so load wins first tie).
REQ-028 Reset asserted mid-ownership SHALL drop the grant without waiting for done.

Verification
REQ-029 Store alone requests in IDLE -> store_granted_o 1 same cycle, owner 10; held through 3 cycles until store_done_i; IDLE next cycle.
REQ-030 Load and store request together from reset -> load granted; after load_done_i, both again -> store granted.
REQ-031 Refill and store request repeatedly, STARVE_LIMIT=4 -> refill wins 4 times, 5th arbitration grants store, starve_cnt returns 0.
REQ-032 Store owns, invalidate miss: store_idle_i=1, store_done_i=0 -> release, owner 00 next cycle.
REQ-033 rst_n_i low while OWN_REFILL -> refill_granted_o 0 asynchronously, owner 00; after release, store request granted same cycle.
REQ-034 Load owns, refill_request_i and store_done_i pulse -> no change; load_granted_o stays 1 until load_done_i.
